// File: rtl/button_sequencer_pkg.sv
// Shared types and constants for the coordinate button transmitter.
package button_sequencer_pkg;

    localparam int unsigned COORD_W          = 4;
    localparam int unsigned NUM_DATA_BITS    = 8;
    localparam int unsigned DEF_PRESS_CYCLES = 2;
    localparam int unsigned DEF_GAP_CYCLES   = 2;
    localparam int unsigned BIT_CNT_W        = 4;
    localparam int unsigned TIMER_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        DATA_PRESS,
        DATA_GAP,
        ACT_PRESS,
        ACT_GAP,
        DONE
    } state_e;

endpackage

// File: rtl/button_sequencer_press_timer.sv
// Down-counting interval timer: load N, expire_o pulses in the Nth cycle after the load.
module press_timer
    import button_sequencer_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (clear_i) begin
            cnt_d = '0;
            run_d = 1'b0;
        end else if (load_i) begin
            cnt_d = load_val_i - W'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/button_sequencer.sv
// Transmits a captured {y,x} coordinate as 8 LSB-first data presses plus one activity press.
module button_sequencer
    import button_sequencer_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES = DEF_PRESS_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic               logic_0_button,
    output logic               logic_1_button,
    output logic               activity_button,
    output logic               busy,
    output logic               done
);

    localparam logic [TIMER_W-1:0]   PRESS_LD = TIMER_W'(PRESS_CYCLES);
    localparam logic [TIMER_W-1:0]   GAP_LD   = TIMER_W'(GAP_CYCLES);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NUM_DATA_BITS);

    state_e                   state_q, state_d;
    logic [2*COORD_W-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                     l0_q, l0_d, l1_q, l1_d, act_q, act_d;
    logic                     busy_q, busy_d, done_q, done_d;
    logic                     tmr_load, tmr_clear, tmr_expire;
    logic [TIMER_W-1:0]       tmr_val;
    logic                     entering;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = DATA_PRESS;
                    shift_d   = {y_in, x_in};
                    bit_cnt_d = '0;
                end
            end
            DATA_PRESS: begin
                if (tmr_expire) begin
                    state_d = DATA_GAP;
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q < LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            DATA_GAP: begin
                if (tmr_expire) begin
                    state_d = (bit_cnt_q >= LAST_BIT) ? ACT_PRESS : DATA_PRESS;
                end
            end
            ACT_PRESS: if (tmr_expire) state_d = ACT_GAP;
            ACT_GAP:   if (tmr_expire) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end
        // The bit count spans the whole data loop, so it is only cleared when returning to IDLE.
        if (state_d == IDLE) begin
            bit_cnt_d = '0;
        end
    end

    always_comb begin
        entering  = (state_d != state_q);
        tmr_clear = entering && (state_d == IDLE || state_d == DONE);
        tmr_load  = entering && !tmr_clear;
        tmr_val   = (state_d == DATA_PRESS || state_d == ACT_PRESS) ? PRESS_LD : GAP_LD;
    end

    press_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // Outputs are registered from the current state so the button lines never glitch;
    // abort overrides the decode so buttons release on the same edge the FSM leaves.
    always_comb begin
        l0_d   = 1'b1;
        l1_d   = 1'b1;
        act_d  = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (!abort) begin
            case (state_q)
                DATA_PRESS: begin
                    busy_d = 1'b1;
                    if (shift_q[0]) l1_d = 1'b0;
                    else            l0_d = 1'b0;
                end
                DATA_GAP:  busy_d = 1'b1;
                ACT_PRESS: begin
                    busy_d = 1'b1;
                    act_d  = 1'b0;
                end
                ACT_GAP:   busy_d = 1'b1;
                DONE:      done_d = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            l0_q      <= 1'b1;
            l1_q      <= 1'b1;
            act_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            l0_q      <= l0_d;
            l1_q      <= l1_d;
            act_q     <= act_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign logic_0_button  = l0_q;
    assign logic_1_button  = l1_q;
    assign activity_button = act_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_button_sequencer.sv
// Scoreboard bench: expected press/gap/done events are queued per DUT and matched by a monitor.
module tb_button_sequencer;

    localparam int K_L0 = 0, K_L1 = 1, K_ACT = 2, K_GAP = 3, K_DONE = 4, K_ABORT = 5;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       start_s[2];
    logic       abort_s[2];
    logic [3:0] x_s[2];
    logic [3:0] y_s[2];
    logic       l0_s[2];
    logic       l1_s[2];
    logic       act_s[2];
    logic       busy_s[2];
    logic       done_s[2];

    ev_t q0[$];
    ev_t q1[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  t0[2] = '{0, 0};
    int  cur_btn[2] = '{-1, -1};
    int  len[2] = '{0, 0};
    int  gap_len[2] = '{0, 0};
    bit  in_seq[2] = '{1'b0, 1'b0};

    button_sequencer u_dut0 (
        .clk (clk), .reset (reset), .start (start_s[0]), .abort (abort_s[0]),
        .x_in (x_s[0]), .y_in (y_s[0]),
        .logic_0_button (l0_s[0]), .logic_1_button (l1_s[0]),
        .activity_button (act_s[0]), .busy (busy_s[0]), .done (done_s[0])
    );

    button_sequencer #(.PRESS_CYCLES(1), .GAP_CYCLES(3)) u_dut1 (
        .clk (clk), .reset (reset), .start (start_s[1]), .abort (abort_s[1]),
        .x_in (x_s[1]), .y_in (y_s[1]),
        .logic_0_button (l0_s[1]), .logic_1_button (l1_s[1]),
        .activity_button (act_s[1]), .busy (busy_s[1]), .done (done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic void push(int i, int kind, int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void push_seq(int i, logic [3:0] x, logic [3:0] y, int p, int g);
        logic [7:0] bits;
        bits = {y, x};
        for (int b = 0; b < 8; b++) begin
            push(i, bits[b] ? K_L1 : K_L0, p);
            push(i, K_GAP, g);
        end
        push(i, K_ACT, p);
        push(i, K_GAP, g);
        push(i, K_DONE, 9 * (p + g) + 1);
    endfunction

    task automatic check_ev(int i, int kind, int val);
        ev_t e;
        bit  have;
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        n_cmp++;
        if (!have) begin
            n_bad++;
            $display("FAIL event dut%0d: got kind=%0d val=%0d, expected no event", i, kind, val);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_bad++;
                $display("FAIL event dut%0d: got kind=%0d val=%0d, expected kind=%0d val=%0d",
                         i, kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic mon_step(int i);
        int btn;
        int lows;
        int rel;
        rel  = cyc - t0[i];
        lows = int'(!l0_s[i]) + int'(!l1_s[i]) + int'(!act_s[i]);
        if (lows > 0) begin
            n_cmp++;
            if (lows > 1) begin
                n_bad++;
                $display("FAIL one_low dut%0d rel=%0d: %0d buttons low, expected at most 1", i, rel, lows);
            end
        end
        btn = !l0_s[i] ? K_L0 : !l1_s[i] ? K_L1 : !act_s[i] ? K_ACT : -1;
        if (btn != cur_btn[i]) begin
            if (cur_btn[i] >= 0) begin
                check_ev(i, cur_btn[i], len[i]);
                gap_len[i] = 0;
            end
            if (btn >= 0) begin
                if (in_seq[i] && gap_len[i] > 0) check_ev(i, K_GAP, gap_len[i]);
                in_seq[i] = 1'b1;
                len[i]    = 1;
            end
            cur_btn[i] = btn;
        end else if (btn >= 0) begin
            len[i]++;
        end
        if (btn < 0) begin
            if (done_s[i]) begin
                if (in_seq[i]) check_ev(i, K_GAP, gap_len[i]);
                check_ev(i, K_DONE, rel);
                in_seq[i]  = 1'b0;
                gap_len[i] = 0;
            end else if (in_seq[i]) begin
                if (!busy_s[i]) begin
                    check_ev(i, K_ABORT, rel);
                    in_seq[i]  = 1'b0;
                    gap_len[i] = 0;
                end else begin
                    gap_len[i]++;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    end

    task automatic chk_idle(int i, string name);
        logic [4:0] got;
        got = {l0_s[i], l1_s[i], act_s[i], busy_s[i], done_s[i]};
        n_cmp++;
        if (got != 5'b11100) begin
            n_bad++;
            $display("FAIL %s dut%0d: {l0,l1,act,busy,done}=%b, expected 11100", name, i, got);
        end
    endtask

    task automatic send(int i, logic [3:0] x, logic [3:0] y);
        @(negedge clk);
        x_s[i]     = x;
        y_s[i]     = y;
        start_s[i] = 1'b1;
        t0[i]      = cyc + 1;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            abort_s[i] = 1'b0;
            x_s[i]     = '0;
            y_s[i]     = '0;
        end
        repeat (3) @(negedge clk);
        chk_idle(0, "in_reset");
        chk_idle(1, "in_reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle(0, "after_reset");
        chk_idle(1, "after_reset");

        // x=1, y=3; inputs change right after capture
        push_seq(0, 4'd1, 4'd3, 2, 2);
        send(0, 4'd1, 4'd3);
        x_s[0] = 4'hA;
        y_s[0] = 4'h5;
        repeat (40) @(negedge clk);

        // x=15, y=0
        push_seq(0, 4'd15, 4'd0, 2, 2);
        send(0, 4'd15, 4'd0);
        repeat (40) @(negedge clk);

        // restart while busy (edge 5) and while in DONE (edge 37) are both ignored
        push_seq(0, 4'd3, 4'd12, 2, 2);
        send(0, 4'd3, 4'd12);
        repeat (4) @(negedge clk);
        x_s[0] = 4'd9; y_s[0] = 4'd6; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (31) @(negedge clk);
        x_s[0] = 4'd1; y_s[0] = 4'd1; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (10) @(negedge clk);

        // abort sampled at edge 11; bits of {9,6}: 0,1,1
        push(0, K_L0, 2); push(0, K_GAP, 2);
        push(0, K_L1, 2); push(0, K_GAP, 2);
        push(0, K_L1, 2); push(0, K_ABORT, 11);
        send(0, 4'd6, 4'd9);
        repeat (10) @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk_idle(0, "after_abort");
        repeat (40) @(negedge clk);
        push_seq(0, 4'd6, 4'd9, 2, 2);
        send(0, 4'd6, 4'd9);
        repeat (40) @(negedge clk);

        // abort and start together in IDLE: nothing starts
        @(negedge clk);
        start_s[0] = 1'b1; abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; abort_s[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk_idle(0, "abort_start_idle");

        // async reset during the 6th press; bits of {10,5}: 1,0,1,0,0,1
        push(0, K_L1, 2); push(0, K_GAP, 2);
        push(0, K_L0, 2); push(0, K_GAP, 2);
        push(0, K_L1, 2); push(0, K_GAP, 2);
        push(0, K_L0, 2); push(0, K_GAP, 2);
        push(0, K_L0, 2); push(0, K_GAP, 2);
        push(0, K_L1, 1); push(0, K_ABORT, 22);
        send(0, 4'd5, 4'd10);
        repeat (21) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_idle(0, "async_reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk_idle(0, "post_reset_idle");

        // PRESS_CYCLES=1, GAP_CYCLES=3
        push_seq(1, 4'd1, 4'd3, 1, 3);
        send(1, 4'd1, 4'd3);
        repeat (40) @(negedge clk);
        push_seq(1, 4'd12, 4'd5, 1, 3);
        send(1, 4'd12, 4'd5);
        repeat (40) @(negedge clk);

        n_cmp++;
        if (q0.size() != 0) begin
            n_bad++;
            $display("FAIL leftover dut0: %0d events pending, expected 0", q0.size());
        end
        n_cmp++;
        if (q1.size() != 0) begin
            n_bad++;
            $display("FAIL leftover dut1: %0d events pending, expected 0", q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
